// File: rtl/dtw_pkg.sv
// dtw_pkg: shared types and helpers for the DTW frame scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: scheduler state enum, default bus widths, saturating increment.
package dtw_pkg;

    localparam int UW_DEF = 7;
    localparam int CW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        RUN   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Increment that sticks at the all-ones value of a 'width'-bit counter.
    // Works on a 64-bit carrier so one function serves any counter width.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int width);
        logic [63:0] max_v;
        max_v = (64'd1 << width) - 64'd1;
        return (val >= max_v) ? val : val + 64'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that saturates at all-ones instead of wrapping.
// Latency: count reflects an inc pulse one cycle later.
// Backpressure: none; one increment per cycle with inc high.
// Ports: clk, rst_geral (async, active high), inc (count request), cnt (value).
module sat_counter
    import dtw_pkg::*;
#(
    parameter int W = CW_DEF
) (
    input  logic         clk,
    input  logic         rst_geral,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            cnt_d = W'(sat_inc(64'(cnt_q), W));
        end
    end

    always_ff @(posedge clk or posedge rst_geral) begin
        if (rst_geral) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/dtw_frame_sched.sv
// dtw_frame_sched: on a zero-cross edge freezes the FIFO fill as one DTW frame,
// releases the DTW processor from reset and lets exactly that many reads through.
// Latency: event -> LATCH -> RUN, one cycle each; fifo_rdreq is combinational
// from proc_rdreq. Backpressure: reads stall on fifo_empty; events while busy
// are dropped and counted.
// Ports: flag_zc/fifo_* /proc_rdreq/proc_done/clr_err in; fifo_rdreq, proc_rst,
// win_len (frame length - 1), busy, frame_cnt, drop_cnt, err_overflow, err_timeout out.
module dtw_frame_sched
    import dtw_pkg::*;
#(
    parameter int UW       = UW_DEF,
    parameter int MIN_LEN  = 4,
    parameter int TIMEOUT  = 4096,
    parameter int HOLD_CYC = 2,
    parameter int CW       = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_geral,
    input  logic          flag_zc,
    input  logic [UW-1:0] fifo_usedw,
    input  logic          fifo_empty,
    input  logic          fifo_full,
    input  logic          proc_rdreq,
    input  logic          proc_done,
    input  logic          clr_err,
    output logic          fifo_rdreq,
    output logic          proc_rst,
    output logic [UW-1:0] win_len,
    output logic          busy,
    output logic [CW-1:0] frame_cnt,
    output logic [CW-1:0] drop_cnt,
    output logic          err_overflow,
    output logic          err_timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int HW = $clog2(HOLD_CYC + 1);
    // A frame of zero samples would make usedw-1 wrap; never accept one.
    localparam int MIN_EFF = (MIN_LEN < 1) ? 1 : MIN_LEN;

    state_t        state_q, state_d;
    logic          flag_zc_q;
    logic [UW-1:0] win_len_q, win_len_d;
    // One bit wider than win_len so it can reach win_len+1 and stop there.
    logic [UW:0]   rd_cnt_q, rd_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          err_ovf_q, err_ovf_d;
    logic          err_tmo_q, err_tmo_d;

    logic          zc_evt;
    logic          len_ok;
    logic          rd_grant;
    logic          tmo_hit;
    logic          tmo_set;
    logic          frame_inc;
    logic          drop_inc;

    assign zc_evt   = flag_zc & ~flag_zc_q;
    assign len_ok   = (fifo_usedw >= UW'(MIN_EFF));
    assign tmo_hit  = (tmo_cnt_q == TW'(TIMEOUT - 1));
    // Depends only on state_q and inputs, so it falls with async reset.
    assign rd_grant = (state_q == RUN) & proc_rdreq & ~fifo_empty
                    & (rd_cnt_q <= {1'b0, win_len_q});

    always_comb begin
        state_d    = state_q;
        win_len_d  = win_len_q;
        rd_cnt_d   = rd_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        hold_cnt_d = hold_cnt_q;
        tmo_set    = 1'b0;
        frame_inc  = 1'b0;
        drop_inc   = 1'b0;
        proc_rst   = 1'b1;
        busy       = 1'b1;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (zc_evt) begin
                    if (len_ok) begin
                        state_d = LATCH;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
            LATCH: begin
                win_len_d = fifo_usedw - UW'(1);
                rd_cnt_d  = '0;
                tmo_cnt_d = '0;
                state_d   = RUN;
            end
            RUN: begin
                proc_rst  = 1'b0;
                tmo_cnt_d = tmo_cnt_q + TW'(1);
                if (rd_grant) begin
                    rd_cnt_d = rd_cnt_q + (UW+1)'(1);
                end
                // A result arriving on the timeout cycle still counts as a frame.
                if (proc_done) begin
                    frame_inc  = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = HOLD;
                end else if (tmo_hit) begin
                    tmo_set    = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt_q == HW'(HOLD_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Events are never queued: anything arriving outside IDLE is lost.
        if (zc_evt && (state_q != IDLE)) begin
            drop_inc = 1'b1;
        end
    end

    // Set beats clear when both happen in the same cycle.
    always_comb begin
        err_ovf_d = err_ovf_q;
        err_tmo_d = err_tmo_q;
        if (clr_err) begin
            err_ovf_d = 1'b0;
            err_tmo_d = 1'b0;
        end
        if (fifo_full && (state_q != RUN)) begin
            err_ovf_d = 1'b1;
        end
        if (tmo_set) begin
            err_tmo_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_geral) begin
        if (rst_geral) begin
            state_q    <= IDLE;
            flag_zc_q  <= 1'b0;
            win_len_q  <= '0;
            rd_cnt_q   <= '0;
            tmo_cnt_q  <= '0;
            hold_cnt_q <= '0;
            err_ovf_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            flag_zc_q  <= flag_zc;
            win_len_q  <= win_len_d;
            rd_cnt_q   <= rd_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            err_ovf_q  <= err_ovf_d;
            err_tmo_q  <= err_tmo_d;
        end
    end

    sat_counter #(.W(CW)) u_frame_cnt (
        .clk       (clk),
        .rst_geral (rst_geral),
        .inc       (frame_inc),
        .cnt       (frame_cnt)
    );

    sat_counter #(.W(CW)) u_drop_cnt (
        .clk       (clk),
        .rst_geral (rst_geral),
        .inc       (drop_inc),
        .cnt       (drop_cnt)
    );

    assign fifo_rdreq   = rd_grant;
    assign win_len      = win_len_q;
    assign err_overflow = err_ovf_q;
    assign err_timeout  = err_tmo_q;

endmodule

// File: doc/dtw_frame_sched.md
Name: dtw_frame_sched

Overview:
Frame scheduler between the sample FIFO, the zero-cross processor and the DTW processor. On a zero-cross event it freezes the current FIFO fill as the frame length and releases the DTW processor from reset. It then gates the processor's FIFO read requests to exactly one frame and waits for the result strobe. It also supervises the frame with a timeout, overflow detection and frame/drop statistics.

Parameters:
UW, 7, width of FIFO usedw and of win_len
MIN_LEN, 4, minimum usedw accepted as a frame
TIMEOUT, 4096, max cycles in RUN before abort
HOLD_CYC, 2, cycles proc_rst is held high after a frame ends
CW, 16, width of frame_cnt and drop_cnt

Ports:
clk  in  1  system clock
rst_geral  in  1  async active-high reset
flag_zc  in  1  zero-cross detected (level, OR of ZC processor result)
fifo_usedw  in  UW  FIFO fill level
fifo_empty  in  1  FIFO empty
fifo_full  in  1  FIFO full
proc_rdreq  in  1  DTW processor read request
proc_done  in  1  DTW processor result strobe (out_en bit 0)
clr_err  in  1  sync clear of sticky errors
fifo_rdreq  out  1  gated read request to FIFO
proc_rst  out  1  DTW processor reset (active high)
win_len  out  UW  frozen frame length minus one, DTW input
busy  out  1  frame in progress
frame_cnt  out  CW  completed frames
drop_cnt  out  CW  rejected zero-cross events
err_overflow  out  1  sticky: FIFO full seen while not RUN
err_timeout  out  1  sticky: RUN aborted by timeout

Behaviour:
- Reset values: fifo_rdreq=0, proc_rst=1, win_len=0, busy=0, counters=0, errors=0, state=IDLE.
- Zero-cross event: rising edge of flag_zc, registered. Event cycle = first cycle flag_zc=1 after a cycle with flag_zc=0.
- IDLE:
  - proc_rst=1.
  - On event with fifo_usedw>=MIN_LEN: go to LATCH.
  - On event with fifo_usedw<MIN_LEN: drop_cnt+1, stay in IDLE.
- LATCH (1 cycle):
  - win_len <= fifo_usedw-1, sampled in this cycle.
  - rd_cnt <= 0, tmo_cnt <= 0, busy=1, proc_rst=1. Next state RUN.
- RUN:
  - proc_rst=0, busy=1.
  - fifo_rdreq = proc_rdreq & !fifo_empty & (rd_cnt<=win_len). This is combinational, with zero latency from proc_rdreq.
  - rd_cnt increments on each granted read. Requests beyond win_len+1 reads are suppressed.
  - tmo_cnt increments every cycle.
  - proc_done=1: frame_cnt+1, go to HOLD. proc_done has priority over timeout in the same cycle.
  - tmo_cnt==TIMEOUT-1 without proc_done: err_timeout<=1, go to HOLD.
  - Events in RUN are not queued: drop_cnt+1 each.
- HOLD:
  - proc_rst=1, busy=1, fifo_rdreq=0.
  - Lasts HOLD_CYC cycles, then IDLE.
  - Events in HOLD: drop_cnt+1.
- err_overflow <= 1 when fifo_full=1 in IDLE, LATCH or HOLD.
- clr_err clears both sticky errors. A set condition in the same cycle wins over clr_err.
- Counters saturate at all-ones; no wrap.
- win_len holds its value outside LATCH.
- fifo_usedw is treated as unsigned. The MIN_LEN>=1 guard prevents underflow of usedw-1.
- rst_geral mid-frame: immediate return to reset values. fifo_rdreq drops asynchronously.

Decomposition:
- Shared package dtw_pkg:
  - state enum (IDLE, LATCH, RUN, HOLD)
  - default UW/CW constants
  - saturating-increment function
- One sub-module: sat_counter, instantiated for frame_cnt and drop_cnt.
- FSM, rd/tmo counters and gating stay in the top.

Test Plan:
- usedw=20, flag_zc rises -> LATCH next cycle, win_len=19, proc_rst falls one cycle later. proc_rdreq held high -> exactly 20 fifo_rdreq pulses, then 0. proc_done -> frame_cnt=1, proc_rst=1 for 2 cycles, then IDLE.
- usedw=3, flag_zc rises -> drop_cnt=1, state stays IDLE, proc_rst stays 1, win_len unchanged.
- RUN with fifo_empty=1 for 5 cycles while proc_rdreq=1 -> fifo_rdreq=0 throughout, rd_cnt unchanged, reads resume when empty deasserts.
- RUN with no proc_done, TIMEOUT=64 -> err_timeout=1 at cycle 64 of RUN, HOLD, then IDLE, frame_cnt=0. clr_err -> err_timeout=0.
- Second flag_zc edge during RUN -> drop_cnt+1, frame completes normally. fifo_full in IDLE -> err_overflow=1 and stays 1.
- rst_geral asserted mid-RUN after 7 reads -> all outputs at reset values immediately. After release, a new frame with usedw=10 gives win_len=9 and 10 reads.
